arb_req_buffer: RTL and testbench

//  Upstream front-end of the 4-way round-robin arbiter. Buffers per-client requests in small FIFOs.

---
 rtl/arb_pkg.sv | 15 +
 rtl/arb_req_buffer_sync_fifo.sv | 42 ++++
 rtl/arb_req_buffer.sv | 85 ++++++++
 tb/tb_arb_req_buffer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared client count, request-vector type and grant decode helpers
package arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int ID_W = $clog2(NUM_REQ);
  typedef logic [NUM_REQ-1:0] req_vec_t;
  function automatic logic is_onehot(input req_vec_t v);
    return (v != '0) && ((v & (v - req_vec_t'(1))) == '0);
  endfunction
  function automatic logic [ID_W-1:0] onehot_to_idx(input req_vec_t v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) idx = v[i] ? (idx | ID_W'(i)) : idx;
    return idx;
  endfunction
endpackage

// File: rtl/arb_req_buffer_sync_fifo.sv
// sync_fifo: per-client circular buffer with occupancy count; DEPTH must be a power of two
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign full = r_count == CW'(DEPTH);
  assign empty = r_count == '0;
  assign w_push = push & !full;
  assign w_pop = pop & !empty;
  assign dout = r_mem[r_rd_ptr];
  assign count = r_count;
  // storage needs no reset: contents are only observable through a non-zero count
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= din;
  // pointers wrap naturally at DEPTH; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/arb_req_buffer.sv
// arb_req_buffer: per-client request FIFOs feeding a round-robin arbiter and a registered output slot
// Define ARB_REQ_BUF_ERR_EN to enable the sticky protocol error flag; otherwise err is tied low.
module arb_req_buffer
  import arb_pkg::*;
#(
  parameter int NUM_REQ = arb_pkg::NUM_REQ,
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          in_valid,
  output logic [NUM_REQ-1:0]          in_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   in_data,
  output logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          grant,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(NUM_REQ)-1:0]  out_id,
  output logic                        err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [DATA_W-1:0] w_dout [NUM_REQ];
  logic [CW-1:0] w_count [NUM_REQ];
  logic [NUM_REQ-1:0] w_full, w_empty, w_push, w_pop, w_req_nxt, r_req;
  logic w_slot_free, w_onehot, w_any_pop;
  logic [IW-1:0] w_gidx;
  logic r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [IW-1:0] r_out_id;
  assign in_ready = ~w_full;
  assign w_push = in_valid & ~w_full;
  assign w_slot_free = !r_out_valid | out_ready;
  assign w_onehot = is_onehot(grant);
  assign w_gidx = onehot_to_idx(grant);
  assign w_pop = (w_onehot && w_slot_free) ? (grant & ~w_empty) : '0;
  assign w_any_pop = |w_pop;
  assign req = r_req;
  assign out_valid = r_out_valid;
  assign out_data = r_out_data;
  assign out_id = r_out_id;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(w_push[i]),
      .pop(w_pop[i]),
      .din(in_data[i*DATA_W +: DATA_W]),
      .dout(w_dout[i]),
      .count(w_count[i]),
      .full(w_full[i]),
      .empty(w_empty[i])
    );
    assign w_req_nxt[i] = (w_count[i] + CW'(w_push[i]) - CW'(w_pop[i])) != '0;
  end
  // req mirrors the post-edge occupancy so it rises in the cycle right after the first push
  always_ff @(posedge clk or posedge rst)
    if (rst) r_req <= '0;
    else r_req <= w_req_nxt;
  // output slot: a pop reloads it (back-to-back when draining), otherwise out_ready empties it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_out_id <= '0;
    end else if (w_any_pop) begin
      r_out_valid <= 1'b1;
      r_out_data <= w_dout[w_gidx];
      r_out_id <= w_gidx;
    end else if (out_ready) r_out_valid <= 1'b0;
`ifdef ARB_REQ_BUF_ERR_EN
  logic w_bad_grant, w_drop, r_err;
  assign w_bad_grant = (grant != '0) && (!w_onehot || (grant & w_empty) != '0);
  assign w_drop = |(in_valid & w_full);
  assign err = r_err;
  // sticky flag for grants to empty FIFOs, non-one-hot grants and dropped pushes
  always_ff @(posedge clk or posedge rst)
    if (rst) r_err <= 1'b0;
    else r_err <= r_err | w_bad_grant | w_drop;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_arb_req_buffer.sv
// tb_arb_req_buffer: directed scoreboard bench for arb_req_buffer; the bench acts as the arbiter
module tb_arb_req_buffer;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] in_valid, in_ready, req, grant;
  logic [31:0] in_data;
  logic out_valid, out_ready, err;
  logic [7:0] out_data;
  logic [1:0] out_id;
  int n_vec = 0;
  int n_bad = 0;
  typedef struct {logic [1:0] id; logic [7:0] data;} txn_t;
  txn_t sb[$];
`ifdef ARB_REQ_BUF_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif
  arb_req_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .req(req), .grant(grant), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_out();
    txn_t t;
    n_vec++;
    assert (sb.size() != 0) else begin
      n_bad++;
      $error("FAIL unexpected_txn observed id=%0d data=%0h expected none", out_id, out_data);
    end
    if (sb.size() != 0) begin
      t = sb.pop_front();
      chk("sb_out_id", 32'(out_id), 32'(t.id));
      chk("sb_out_data", 32'(out_data), 32'(t.data));
    end
  endtask
  // one clock: a new transaction is in the slot when out_valid is set and the slot was empty or just taken
  task automatic cyc();
    logic pv, take;
    pv = out_valid;
    take = out_valid & out_ready;
    @(posedge clk);
    #1;
    if (out_valid && (take || !pv)) check_out();
  endtask
  task automatic set_data(input int i, input logic [7:0] d);
    in_data[i*8 +: 8] = d;
  endtask
  function automatic logic [7:0] wv(input int n);
    return 8'h40 + 8'(n * 13);
  endfunction
  initial begin
    rst = 1'b1; in_valid = 4'b1111; grant = '0; out_ready = 1'b1; in_data = '0;
    cyc(); cyc();
    chk("rst_req", 32'(req), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 32'hF);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_id", 32'(out_id), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0; in_valid = '0;
    cyc();
    chk("rst_no_push_req", 32'(req), 0);
    chk("rst_no_push_ready", 32'(in_ready), 32'hF);
    set_data(2, 8'hA5); in_valid = 4'b0100;
    cyc();
    in_valid = '0;
    chk("single_req_t1", 32'(req), 32'h4);
    cyc();
    grant = 4'b0100; sb.push_back('{2'd2, 8'hA5});
    cyc();
    chk("single_out_valid_t3", 32'(out_valid), 1);
    chk("single_req_t3", 32'(req), 0);
    grant = '0;
    cyc();
    chk("single_drain", 32'(out_valid), 0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) set_data(i, 8'(16 * i + k));
      in_valid = 4'b1111;
      cyc();
    end
    in_valid = '0;
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_req", 32'(req), 32'hF);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) begin
        grant = 4'(1 << i);
        sb.push_back('{2'(i), 8'(16 * i + k)});
        cyc();
      end
    grant = '0;
    cyc();
    chk("full_drained_valid", 32'(out_valid), 0);
    chk("full_drained_req", 32'(req), 0);
    chk("full_drained_ready", 32'(in_ready), 32'hF);
    in_valid = 4'b0001; set_data(0, 8'hC0);
    cyc();
    set_data(0, 8'hC1);
    cyc();
    in_valid = '0; grant = 4'b0001; sb.push_back('{2'd0, 8'hC0});
    cyc();
    out_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      cyc();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'hC0);
      chk("bp_id", 32'(out_id), 0);
      chk("bp_req", 32'(req), 32'h1);
    end
    out_ready = 1'b1; sb.push_back('{2'd0, 8'hC1});
    cyc();
    chk("bp_reload_valid", 32'(out_valid), 1);
    chk("bp_reload_req", 32'(req), 0);
    grant = '0;
    cyc();
    chk("bp_drain", 32'(out_valid), 0);
    chk("err_clean", 32'(err), 0);
    in_valid = 4'b0011; set_data(0, 8'hD0); set_data(1, 8'hD1);
    cyc();
    in_valid = '0; grant = 4'b0011;
    cyc();
    chk("bad_multi_valid", 32'(out_valid), 0);
    chk("bad_multi_req", 32'(req), 32'h3);
    grant = 4'b1000;
    cyc();
    chk("bad_empty_valid", 32'(out_valid), 0);
    chk("bad_empty_req", 32'(req), 32'h3);
    chk("bad_err", 32'(err), 32'(ERR_EXP));
    grant = 4'b0001; sb.push_back('{2'd0, 8'hD0});
    cyc();
    grant = 4'b0010; sb.push_back('{2'd1, 8'hD1});
    cyc();
    grant = '0;
    cyc();
    chk("bad_drain", 32'(out_valid), 0);
    chk("bad_err_sticky", 32'(err), 32'(ERR_EXP));
    in_valid = 4'b0010; set_data(1, wv(0));
    cyc();
    set_data(1, wv(1));
    cyc();
    for (int n = 0; n < 12; n++) begin
      set_data(1, wv(n + 2)); grant = 4'b0010; sb.push_back('{2'd1, wv(n)});
      cyc();
      chk("wrap_req", 32'(req), 32'h2);
      chk("wrap_ready", 32'(in_ready), 32'hF);
    end
    in_valid = '0; sb.push_back('{2'd1, wv(12)});
    cyc();
    sb.push_back('{2'd1, wv(13)});
    cyc();
    grant = '0;
    cyc();
    chk("wrap_req_empty", 32'(req), 0);
    chk("wrap_drain", 32'(out_valid), 0);
    in_valid = 4'b1000; set_data(3, 8'h77);
    cyc();
    in_valid = '0;
    chk("mid_rst_req_pre", 32'(req), 32'h8);
    grant = 4'b1000; rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(req), 0);
    chk("mid_rst_ready", 32'(in_ready), 32'hF);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_err", 32'(err), 0);
    cyc();
    rst = 1'b0; grant = '0;
    cyc();
    chk("post_rst_req", 32'(req), 0);
    chk("post_rst_valid", 32'(out_valid), 0);
    chk("sb_leftover", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
